// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe writeback path.
//   wb_entry_t : one delay-line stage {valid, reg_write, rt, data}
//   DATA_W     : result width
//   REG_AW     : register address width (128 registers)
//   MAX_LAT    : largest encodable latency; delay line holds MAX_LAT+1 stages
package spu_pkg;

    localparam int unsigned DATA_W        = 128;
    localparam int unsigned REG_AW        = 7;
    localparam int unsigned MAX_LAT       = 7;
    localparam int unsigned EVEN_PIPE_LAT = 2;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rt;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hazard_cmp.sv
// Compares one operand-read address against the writeback delay line.
//   rd_addr_i : operand address being read
//   wr_vec_i  : per-stage "will write" bit (valid && reg_write), stage 0 at bit 0
//   rt_vec_i  : per-stage destination register, stage i at [i*REG_AW +: REG_AW]
//   hazard_o  : operand still pending in stages 1..MAX_LAT
//   fwd_o     : operand being written back from stage 0 this cycle
module wb_hazard_cmp
    import spu_pkg::*;
(
    input  logic [REG_AW-1:0]             rd_addr_i,
    input  logic [MAX_LAT:0]              wr_vec_i,
    input  logic [(MAX_LAT+1)*REG_AW-1:0] rt_vec_i,
    output logic                          hazard_o,
    output logic                          fwd_o
);

    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned i = 1; i <= MAX_LAT; i++) begin
            if (wr_vec_i[i] && (rt_vec_i[i*REG_AW +: REG_AW] == rd_addr_i)) begin
                hazard_o = 1'b1;
            end
        end
        fwd_o = wr_vec_i[0] && (rt_vec_i[REG_AW-1:0] == rd_addr_i);
    end

endmodule

// File: rtl/even_pipe_wb_scheduler.sv
// Even-pipe writeback scheduler. Each accepted result is dropped into a
// latency-indexed delay line and retires on the single writeback port in its
// exact completion cycle. Also produces issue back-pressure on writeback-slot
// collisions, RAW hazard flags and stage-0 forwarding flags.
//   clk, reset                : clock, synchronous active-high reset
//   issue_*                   : op handshake, latency, destination, result
//   flush                     : drop every in-flight op (wins over issue)
//   wb_valid/wb_rt/wb_data    : register-file write port
//   rd_ra/rd_rb/rd_rc         : operand addresses being read
//   hazard_r*/fwd_r*          : pending-in-pipe / available-from-stage-0 flags
//   in_flight                 : number of occupied stages
module even_pipe_wb_scheduler
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_latency,
    input  logic [REG_AW-1:0] issue_rt,
    input  logic              issue_reg_write,
    input  logic [DATA_W-1:0] issue_result,
    input  logic              flush,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rt,
    output logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] rd_ra,
    input  logic [REG_AW-1:0] rd_rb,
    input  logic [REG_AW-1:0] rd_rc,
    output logic              hazard_ra,
    output logic              hazard_rb,
    output logic              hazard_rc,
    output logic              fwd_ra,
    output logic              fwd_rb,
    output logic              fwd_rc,
    output logic [3:0]        in_flight
);

    wb_entry_t stage_q [MAX_LAT+1];
    wb_entry_t stage_d [MAX_LAT+1];

    // Extra top bit models the always-invalid stage beyond MAX_LAT.
    logic [MAX_LAT+1:0]            valid_vec;
    logic [3:0]                    ready_idx;
    logic                          issue_fire;
    logic [MAX_LAT:0]              wr_vec;
    logic [(MAX_LAT+1)*REG_AW-1:0] rt_vec;

    always_comb begin
        valid_vec = '0;
        wr_vec    = '0;
        rt_vec    = '0;
        for (int unsigned i = 0; i <= MAX_LAT; i++) begin
            valid_vec[i]               = stage_q[i].valid;
            wr_vec[i]                  = stage_q[i].valid && stage_q[i].reg_write;
            rt_vec[i*REG_AW +: REG_AW] = stage_q[i].rt;
        end
    end

    // An op of latency L lands in stage L after the shift, i.e. where stage L+1
    // is now. It may only go there if that slot is empty.
    always_comb begin
        ready_idx   = {1'b0, issue_latency} + 4'd1;
        issue_ready = ~valid_vec[ready_idx];
        issue_fire  = issue_valid && issue_ready;
    end

    always_comb begin
        for (int unsigned i = 0; i < MAX_LAT; i++) begin
            stage_d[i] = stage_q[i+1];
        end
        stage_d[MAX_LAT] = '0;

        if (issue_fire) begin
            stage_d[issue_latency] = '{valid:     1'b1,
                                       reg_write: issue_reg_write,
                                       rt:        issue_rt,
                                       data:      issue_result};
        end

        if (flush) begin
            for (int unsigned i = 0; i <= MAX_LAT; i++) begin
                stage_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i <= MAX_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i <= MAX_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        wb_valid = stage_q[0].valid && stage_q[0].reg_write;
        wb_rt    = stage_q[0].rt;
        wb_data  = stage_q[0].data;
    end

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i <= MAX_LAT; i++) begin
            in_flight = in_flight + {3'b000, stage_q[i].valid};
        end
    end

    wb_hazard_cmp u_cmp_ra (
        .rd_addr_i (rd_ra),
        .wr_vec_i  (wr_vec),
        .rt_vec_i  (rt_vec),
        .hazard_o  (hazard_ra),
        .fwd_o     (fwd_ra)
    );

    wb_hazard_cmp u_cmp_rb (
        .rd_addr_i (rd_rb),
        .wr_vec_i  (wr_vec),
        .rt_vec_i  (rt_vec),
        .hazard_o  (hazard_rb),
        .fwd_o     (fwd_rb)
    );

    wb_hazard_cmp u_cmp_rc (
        .rd_addr_i (rd_rc),
        .wr_vec_i  (wr_vec),
        .rt_vec_i  (rt_vec),
        .hazard_o  (hazard_rc),
        .fwd_o     (fwd_rc)
    );

endmodule
